// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the cache controllers and the line fetch
// engine.
//   fetch_cmd_t     : encoding of the fetch command bus (2'b1x is a no-op)
//   fetch_state_t   : state of the line fetch engine
//   line_offset_bits: byte-offset width of one cache line
//   LINE_OFFSET_W   : line byte-offset width for the default geometry
//                     (32 words of 32 bits)
// ---------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    FETCH_WB   = 2'b00,
    FETCH_FILL = 2'b01
  } fetch_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_NOP,
    ST_WB_ADDR,
    ST_WB_RD,
    ST_WB_DATA,
    ST_WB_RESP,
    ST_FILL_ADDR,
    ST_FILL_DATA,
    ST_DONE
  } fetch_state_t;

  // Number of low byte-address bits covered by one line of `words` words,
  // each `word_bits` wide.
  function automatic int line_offset_bits(input int words, input int word_bits);
    return $clog2(words * word_bits / 8);
  endfunction

  localparam int LINE_OFFSET_W = line_offset_bits(32, 32);

endpackage

// File: rtl/line_fetch_engine.sv
// ---------------------------------------------------------------------------
// line_fetch_engine
// Executes one cache-line transfer at a time between the local data RAM and
// external memory.
//   writeback : read the line word by word from the RAM and stream it out as
//               an external write burst, then wait for the burst response.
//   fill      : accept an external read burst and write each beat straight
//               into the RAM.
//   no-op     : complete without touching RAM or external memory.
// fetch_done pulses for one cycle when a command completes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_req/cmd/tag/addr     command from the controllers
//   fetch_gnt                  high while idle (command accepted on req)
//   fetch_done                 one-cycle completion pulse
//   mem_raddr/ren/rready/rdata RAM read port ({tag, beat} word address,
//                              data returns the cycle after the accept)
//   mem_waddr/wen/wready/wdata RAM write port
//   ext_rd_*                   external read burst (request, beats in)
//   ext_wr_*                   external write burst (request, beats out,
//                              commit response)
// ---------------------------------------------------------------------------
module line_fetch_engine
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              fetch_req,
  input  logic [1:0]                                        fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                     fetch_tag,
  input  logic [addr_width-1:0]                             fetch_addr,
  output logic                                              fetch_gnt,
  output logic                                              fetch_done,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]  mem_raddr,
  output logic                                              mem_ren,
  input  logic                                              mem_rready,
  input  logic [data_width-1:0]                             mem_rdata,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0]  mem_waddr,
  output logic                                              mem_wen,
  input  logic                                              mem_wready,
  output logic [data_width-1:0]                             mem_wdata,
  output logic                                              ext_rd_req,
  output logic [addr_width-1:0]                             ext_rd_addr,
  input  logic                                              ext_rd_gnt,
  input  logic                                              ext_rd_valid,
  input  logic [data_width-1:0]                             ext_rd_data,
  output logic                                              ext_rd_ready,
  output logic                                              ext_wr_req,
  output logic [addr_width-1:0]                             ext_wr_addr,
  input  logic                                              ext_wr_gnt,
  output logic                                              ext_wr_valid,
  output logic [data_width-1:0]                             ext_wr_data,
  output logic                                              ext_wr_last,
  input  logic                                              ext_wr_ready,
  input  logic                                              ext_wr_resp
);

  localparam int TW = $clog2(list_depth);
  localparam int BW = $clog2(list_width);
  localparam int OW = line_offset_bits(list_width, data_width);

  // Clears the byte offset within a line so bursts always start aligned.
  localparam logic [addr_width-1:0] ADDR_MASK = {addr_width{1'b1}} << OW;
  localparam logic [BW-1:0]         LAST_BEAT = BW'(list_width - 1);

  fetch_state_t          state_reg;
  logic [BW-1:0]         beat_reg;
  logic [TW-1:0]         tag_reg;
  logic [addr_width-1:0] addr_reg;
  logic [data_width-1:0] hold_reg;
  // Set for the cycle in which RAM read data is on mem_rdata.
  logic                  rd_pend_reg;

  logic in_fill_data;
  logic last_beat;

  assign in_fill_data = (state_reg == ST_FILL_DATA);
  assign last_beat    = (beat_reg == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      beat_reg    <= '0;
      tag_reg     <= '0;
      addr_reg    <= '0;
      hold_reg    <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      rd_pend_reg <= 1'b0;
      if (rd_pend_reg) begin
        hold_reg <= mem_rdata;
      end

      case (state_reg)
        ST_IDLE: begin
          if (fetch_req) begin
            tag_reg  <= fetch_tag;
            addr_reg <= fetch_addr & ADDR_MASK;
            case (fetch_cmd)
              FETCH_WB:   state_reg <= ST_WB_ADDR;
              FETCH_FILL: state_reg <= ST_FILL_ADDR;
              default:    state_reg <= ST_NOP;
            endcase
          end
        end

        ST_NOP: state_reg <= ST_DONE;

        ST_WB_ADDR: begin
          if (ext_wr_gnt) begin
            state_reg <= ST_WB_RD;
          end
        end

        ST_WB_RD: begin
          if (mem_rready) begin
            rd_pend_reg <= 1'b1;
            state_reg   <= ST_WB_DATA;
          end
        end

        ST_WB_DATA: begin
          if (ext_wr_ready) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= ST_WB_RESP;
            end else begin
              beat_reg  <= beat_reg + BW'(1);
              state_reg <= ST_WB_RD;
            end
          end
        end

        ST_WB_RESP: begin
          if (ext_wr_resp) begin
            state_reg <= ST_DONE;
          end
        end

        ST_FILL_ADDR: begin
          if (ext_rd_gnt) begin
            state_reg <= ST_FILL_DATA;
          end
        end

        ST_FILL_DATA: begin
          if (ext_rd_valid && mem_wready) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= ST_DONE;
            end else begin
              beat_reg <= beat_reg + BW'(1);
            end
          end
        end

        ST_DONE: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fetch_gnt  = (state_reg == ST_IDLE);
  assign fetch_done = (state_reg == ST_DONE);

  // Writeback side: one RAM read per beat, then present that word.
  assign mem_raddr    = {tag_reg, beat_reg};
  assign mem_ren      = (state_reg == ST_WB_RD);
  assign ext_wr_req   = (state_reg == ST_WB_ADDR);
  assign ext_wr_addr  = addr_reg;
  assign ext_wr_valid = (state_reg == ST_WB_DATA);
  assign ext_wr_last  = (state_reg == ST_WB_DATA) && last_beat;
  // The first WB_DATA cycle forwards the RAM data directly; later cycles of
  // a stalled beat replay it from the hold register.
  assign ext_wr_data  = rd_pend_reg ? mem_rdata : hold_reg;

  // Fill side: external beats pass straight through to the RAM write port,
  // throttled by the RAM's write ready.
  assign ext_rd_req   = (state_reg == ST_FILL_ADDR);
  assign ext_rd_addr  = addr_reg;
  assign ext_rd_ready = in_fill_data && mem_wready;
  assign mem_waddr    = {tag_reg, beat_reg};
  assign mem_wen      = in_fill_data && ext_rd_valid;
  assign mem_wdata    = in_fill_data ? ext_rd_data : '0;

endmodule

// File: tb/tb_line_fetch_engine.sv
module tb_line_fetch_engine;

  localparam int AW = 32;
  localparam int LD = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [1:0]    fetch_cmd = '0;
  logic [1:0]    fetch_tag = '0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_done;
  logic [3:0]    mem_raddr, mem_waddr;
  logic          mem_ren, mem_wen;
  logic          mem_rready = 1'b0, mem_wready = 1'b0;
  logic [DW-1:0] mem_rdata = '0, mem_wdata;
  logic          ext_rd_req, ext_rd_ready, ext_wr_req, ext_wr_valid, ext_wr_last;
  logic [AW-1:0] ext_rd_addr, ext_wr_addr;
  logic          ext_rd_gnt = 1'b0, ext_rd_valid = 1'b0;
  logic [DW-1:0] ext_rd_data = '0, ext_wr_data;
  logic          ext_wr_gnt = 1'b0, ext_wr_ready = 1'b0, ext_wr_resp = 1'b0;

  line_fetch_engine #(
    .addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
    .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
    .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .ext_rd_req(ext_rd_req), .ext_rd_addr(ext_rd_addr), .ext_rd_gnt(ext_rd_gnt),
    .ext_rd_valid(ext_rd_valid), .ext_rd_data(ext_rd_data), .ext_rd_ready(ext_rd_ready),
    .ext_wr_req(ext_wr_req), .ext_wr_addr(ext_wr_addr), .ext_wr_gnt(ext_wr_gnt),
    .ext_wr_valid(ext_wr_valid), .ext_wr_data(ext_wr_data), .ext_wr_last(ext_wr_last),
    .ext_wr_ready(ext_wr_ready), .ext_wr_resp(ext_wr_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic outs_or();
    return |{fetch_done, mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata,
             ext_rd_req, ext_rd_addr, ext_rd_ready, ext_wr_req, ext_wr_addr,
             ext_wr_valid, ext_wr_data, ext_wr_last};
  endfunction

  // Bench-side RAM contents and transaction model.
  logic [DW-1:0] ram [LD*LW];
  logic [DW-1:0] pend_fill [LW];
  logic [DW-1:0] act_fill [LW];
  bit            m_busy, m_granted, m_have, m_resp_wait;
  int            m_kind, m_op, m_tag, m_beats;
  logic [AW-1:0] m_addr;
  bit            rd_due;
  int            rd_due_idx;
  int            cyc, hs_count, done_model, done_dut, hs_cycle, resp_cycle, dut_done_cycle;
  int            act_cnt, last_cnt, stall_cnt, mode;
  bit            tog;
  logic [AW-1:0] last_rd_addr, last_wr_addr;
  int            lit_waddr[$];
  logic [DW-1:0] lit_data[$];
  bit            c_fr, c_wr, c_fd, c_rr, c_wd;

  // Compare process: m_kind 0 = writeback, 1 = fill, 2 = no-op, 3 = completing.
  always @(negedge clk) begin
    cyc++;
    rd_due = 1'b0;
    if (fetch_done) begin
      done_dut++;
      dut_done_cycle = cyc;
    end
    if (ext_rd_req | ext_wr_req | mem_ren | mem_wen | ext_wr_valid) act_cnt++;
    if (ext_rd_req) last_rd_addr = ext_rd_addr;
    if (ext_wr_req) last_wr_addr = ext_wr_addr;
    if (!rst_n) begin
      m_busy = 0; m_kind = 0; m_granted = 0; m_beats = 0; m_have = 0; m_resp_wait = 0;
      chk("rst_gnt", fetch_gnt, 1);
      chk("rst_outputs", outs_or(), 0);
    end else begin
      c_fr = m_busy && m_kind == 1 && !m_granted;
      c_wr = m_busy && m_kind == 0 && !m_granted;
      c_fd = m_busy && m_kind == 1 && m_granted;
      c_rr = m_busy && m_kind == 0 && m_granted && !m_resp_wait && !m_have;
      c_wd = m_busy && m_kind == 0 && m_have;
      chk("fetch_gnt", fetch_gnt, !m_busy);
      chk("fetch_done", fetch_done, m_busy && m_kind == 3);
      chk("ext_rd_req", ext_rd_req, c_fr);
      chk("ext_wr_req", ext_wr_req, c_wr);
      if (c_fr) chk("ext_rd_addr", ext_rd_addr, m_addr & ~32'hF);
      if (c_wr) chk("ext_wr_addr", ext_wr_addr, m_addr & ~32'hF);
      chk("ext_rd_ready", ext_rd_ready, c_fd ? mem_wready : 1'b0);
      chk("mem_wen", mem_wen, c_fd ? ext_rd_valid : 1'b0);
      chk("mem_ren", mem_ren, c_rr);
      chk("ext_wr_valid", ext_wr_valid, c_wd);
      if (c_wd) begin
        chk("wb_data", ext_wr_data, ram[m_tag*LW + m_beats]);
        chk("wb_last", ext_wr_last, m_beats == LW-1);
      end

      if (m_busy && m_kind == 3) begin
        m_busy = 0;
        done_model++;
        $display("txn %0d op=%0d tag=%0d addr=%08h done at cycle %0d",
                 done_model, m_op, m_tag, m_addr, cyc);
      end else if (!m_busy) begin
        if (fetch_req) begin
          m_busy = 1; m_granted = 0; m_beats = 0; m_have = 0; m_resp_wait = 0;
          m_op = int'(fetch_cmd);
          m_kind = (fetch_cmd == 2'b00) ? 0 : (fetch_cmd == 2'b01) ? 1 : 2;
          m_tag = int'(fetch_tag);
          m_addr = fetch_addr;
          for (int i = 0; i < LW; i++) act_fill[i] = pend_fill[i];
          hs_cycle = cyc;
          hs_count++;
        end
      end else if (m_kind == 2) begin
        m_kind = 3;
      end else if (m_kind == 1) begin
        if (!m_granted) begin
          if (ext_rd_gnt) m_granted = 1;
        end else if (ext_rd_valid && mem_wready) begin
          chk("fill_waddr", mem_waddr, m_tag*LW + m_beats);
          chk("fill_wdata", mem_wdata, act_fill[m_beats]);
          ram[m_tag*LW + m_beats] = act_fill[m_beats];
          lit_waddr.push_back(int'(mem_waddr));
          lit_data.push_back(mem_wdata);
          m_beats++;
          if (m_beats == LW) m_kind = 3;
        end
      end else begin
        if (!m_granted) begin
          if (ext_wr_gnt) m_granted = 1;
        end else if (m_resp_wait) begin
          if (ext_wr_resp) begin
            m_kind = 3;
            resp_cycle = cyc;
          end
        end else if (!m_have) begin
          if (mem_rready) begin
            chk("wb_raddr", mem_raddr, m_tag*LW + m_beats);
            m_have = 1;
            rd_due = 1'b1;
            rd_due_idx = m_tag*LW + m_beats;
          end
        end else if (ext_wr_ready) begin
          lit_data.push_back(ext_wr_data);
          if (ext_wr_last) last_cnt++;
          m_beats++;
          m_have = 0;
          if (m_beats == LW) m_resp_wait = 1;
        end
      end
    end
  end

  // External memory / RAM responders.
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (mode)
      1, 2: begin
        mem_rready = 1; mem_wready = 1; ext_rd_gnt = 1; ext_wr_gnt = 1; ext_rd_valid = 1;
        ext_wr_ready = (mode == 2) ? tog : 1'b1;
        ext_wr_resp = m_busy && m_kind == 0 && m_resp_wait;
      end
      3: begin
        mem_rready = 1; ext_rd_gnt = 1; ext_wr_gnt = 1; ext_rd_valid = 1; ext_wr_ready = 1;
        ext_wr_resp = 0;
        if (m_kind == 1 && m_granted && m_beats == 2 && stall_cnt < 3) begin
          mem_wready = 0;
          stall_cnt++;
        end else begin
          mem_wready = 1;
        end
      end
      default: begin
        mem_rready   = ($urandom_range(0, 9) < 6);
        mem_wready   = ($urandom_range(0, 9) < 7);
        ext_rd_gnt   = ($urandom_range(0, 9) < 5);
        ext_wr_gnt   = ($urandom_range(0, 9) < 5);
        ext_rd_valid = ($urandom_range(0, 9) < 7);
        ext_wr_ready = ($urandom_range(0, 9) < 6);
        ext_wr_resp  = ($urandom_range(0, 3) == 0);
      end
    endcase
    mem_rdata = rd_due ? ram[rd_due_idx] : $urandom;
    ext_rd_data = (ext_rd_valid && m_kind == 1 && m_beats < LW) ? act_fill[m_beats] : $urandom;
  end

  task automatic send(input logic [1:0] c, input logic [1:0] t, input logic [AW-1:0] a);
    int n;
    fetch_req = 1'b1; fetch_cmd = c; fetch_tag = t; fetch_addr = a;
    n = 0;
    @(negedge clk);
    while (!fetch_gnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no grant expected grant within 500 cycles");
    end
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (m_busy && n < 2000);
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got busy expected idle within 2000 cycles");
    end
  endtask

  initial begin
    int d0, a0, n;
    int exp_waddr [4];
    exp_waddr = '{8, 9, 10, 11};
    mode = 1;
    for (int i = 0; i < LD*LW; i++) ram[i] = $urandom;
    for (int i = 0; i < LW; i++) ram[LW + i] = 32'hD0 + i;
    for (int i = 0; i < LW; i++) pend_fill[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("reset_gnt", fetch_gnt, 1);
    chk("reset_outputs", outs_or(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill tag 2 at 0x100, data A0..A3, RAM always ready.
    mode = 1;
    for (int i = 0; i < LW; i++) pend_fill[i] = 32'hA0 + i;
    lit_waddr.delete(); lit_data.delete();
    d0 = done_dut;
    send(2'b01, 2'd2, 32'h100);
    wait_idle();
    chk("t1_beats", lit_waddr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < lit_waddr.size()) begin
        chk("t1_waddr", lit_waddr[i], exp_waddr[i]);
        chk("t1_wdata", lit_data[i], 32'hA0 + i);
      end
    end
    chk("t1_rd_addr", last_rd_addr, 32'h100);
    chk("t1_done_count", done_dut - d0, 1);

    // Writeback tag 1 (D0..D3) with ext_wr_ready toggling; unaligned address.
    mode = 2;
    lit_data.delete();
    last_cnt = 0;
    send(2'b00, 2'd1, 32'h247);
    wait_idle();
    chk("t2_beats", lit_data.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < lit_data.size()) chk("t2_wdata", lit_data[i], 32'hD0 + i);
    chk("t2_last_count", last_cnt, 1);
    chk("t2_wr_addr", last_wr_addr, 32'h240);
    chk("t2_done_after_resp", dut_done_cycle - resp_cycle, 1);

    // Fill with a 3-cycle RAM stall mid-burst, then write the line back.
    mode = 3;
    stall_cnt = 0;
    for (int i = 0; i < LW; i++) pend_fill[i] = $urandom;
    lit_data.delete();
    send(2'b01, 2'd0, 32'h3C0);
    wait_idle();
    chk("t3_stall_cycles", stall_cnt, 3);
    chk("t3_beats", lit_data.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < lit_data.size()) chk("t3_wdata", lit_data[i], pend_fill[i]);
    mode = 0;
    send(2'b00, 2'd0, 32'h3C0);
    wait_idle();

    // No-op command.
    mode = 1;
    a0 = act_cnt;
    send(2'b10, 2'd3, 32'h500);
    wait_idle();
    chk("t4_done_latency", dut_done_cycle - hs_cycle, 2);
    chk("t4_activity", act_cnt - a0, 0);

    // Back-to-back random commands, request held high while busy.
    mode = 0;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < LW; i++) pend_fill[i] = $urandom;
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    end
    wait_idle();
    chk("t5_done_model", done_model, hs_count);
    chk("t5_done_dut", done_dut, hs_count);

    // Reset in the middle of writeback beat 2.
    mode = 1;
    send(2'b00, 2'd3, 32'h780);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(m_kind == 0 && m_have && m_beats == 2) && n < 200);
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL t6_reach_beat2: got no beat 2 expected beat 2 within 200 cycles");
    end
    @(posedge clk); #2;
    chk("t6_pre_valid", ext_wr_valid, 1);
    d0 = done_dut;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", fetch_gnt, 1);
    chk("t6_rst_outputs", outs_or(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_no_done", done_dut - d0, 0);
    mode = 0;
    for (int i = 0; i < LW; i++) pend_fill[i] = $urandom;
    send(2'b01, 2'd1, 32'h9A0);
    wait_idle();
    chk("t6_final_done_model", done_model, hs_count - 1);
    chk("t6_final_done_dut", done_dut, done_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
